// File: rtl/trng_uart_ctrl_if.sv
// Byte stream handshake between the TRNG controller (master) and the UART transmitter (slave).
interface trng_uart_ctrl_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/trng_uart_ctrl.sv
// TRNG sampling, von Neumann debiasing, byte packing and FIFO buffering towards the UART,
// with a repetition-count health test that blocks output when the source looks stuck.
//
// state     | meaning
// VN_FIRST  | waiting for the first bit (a) of a sample pair
// VN_SECOND | bit a held, next strobe supplies bit b and may emit
module trng_uart_ctrl #(
  parameter int SAMPLE_DIV = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        rnd_raw,
  trng_uart_ctrl_if.master            tx,
  output logic                        health_fail,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {VN_FIRST, VN_SECOND} vn_state_t;

  logic            sync1, rnd_s;
  logic [7:0]      div_cnt;
  logic            strobe, act;
  logic            prev_smp, hist_valid;
  logic [7:0]      rep_cnt, rep_next;
  logic            fail_now;
  vn_state_t       vn_state, vn_next;
  logic            bit_a, emit, emit_bit;
  logic [6:0]      sr;
  logic [2:0]      bit_cnt;
  logic            push, pop, accept;
  logic [7:0]      push_data;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      rnd_s <= 1'b0;
    end else begin
      sync1 <= rnd_raw;
      rnd_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en)
      div_cnt <= '0;
    else if (div_cnt == 8'(SAMPLE_DIV - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 8'd1;
  end

  assign strobe = en && (div_cnt == 8'(SAMPLE_DIV - 1));
  assign act    = strobe && !health_fail;

  assign rep_next = (hist_valid && rnd_s == prev_smp)
                  ? ((rep_cnt == 8'(REP_LIMIT)) ? rep_cnt : rep_cnt + 8'd1)
                  : 8'd1;
  assign fail_now = act && (rep_next == 8'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_smp    <= 1'b0;
      hist_valid  <= 1'b0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (!en) begin
      hist_valid <= 1'b0;
      rep_cnt    <= '0;
    end else if (act) begin
      prev_smp   <= rnd_s;
      hist_valid <= 1'b1;
      rep_cnt    <= rep_next;
      if (fail_now)
        health_fail <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vn_state <= VN_FIRST;
      bit_a    <= 1'b0;
    end else begin
      vn_state <= vn_next;
      if (act && vn_state == VN_FIRST)
        bit_a <= rnd_s;
    end
  end

  // Disabling or a health failure drops any half-formed pair.
  always_comb begin
    vn_next  = vn_state;
    emit     = 1'b0;
    emit_bit = bit_a;
    if (!en || fail_now) begin
      vn_next = VN_FIRST;
    end else if (act) begin
      case (vn_state)
        VN_FIRST:  vn_next = VN_SECOND;
        VN_SECOND: begin
          vn_next = VN_FIRST;
          emit    = (bit_a != rnd_s);
        end
        default:   vn_next = VN_FIRST;
      endcase
    end
  end

  assign push_data = {sr, emit_bit};
  assign push      = emit && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst || !en || fail_now) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (emit) begin
      sr      <= push_data[6:0];
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign pop    = tx.tx_valid && tx.tx_ready;
  assign accept = push && ((count < CW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (fail_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !accept)
        overflow <= 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign tx.tx_valid = (count != '0) && !health_fail;
  assign tx.tx_data  = mem[rd_ptr];
  assign fifo_count  = count;
endmodule
